fun_fpcvt_lanes: RTL and testbench



---
 rtl/fun_fpcvt_lanes.sv | 199 +++++++++++++++++++
 tb/tb_fun_fpcvt_lanes.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fun_fpcvt_lanes.sv
// Multi-lane binary64/binary32 to signed-integer converter with a STAGES-deep pipeline and a global stall.
// Optional sticky exception accumulator enabled by defining FPCVT_STICKY_EN.
module fun_fpcvt_lanes #(
  parameter int LANES  = 3,
  parameter int STAGES = 2,
  parameter int RM_LSB = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           fpcsr,
  input  logic                  clkEn,
  input  logic [LANES-1:0]      en,
  input  logic [LANES*68-1:0]   A,
  input  logic [LANES-1:0]      isDBL,
  input  logic [LANES-1:0]      is32b,
`ifdef FPCVT_STICKY_EN
  input  logic                  sticky_clr,
  output logic [1:0]            sticky_exc,
`endif
  output logic [LANES*64-1:0]   res,
  output logic [LANES-1:0]      res_en,
  output logic [LANES*2-1:0]    exc
);

  // Unpacked operand: integer magnitude plus guard/sticky, and the special cases
  typedef struct packed {
    logic        valid;
    logic        sign;
    logic [63:0] mag;
    logic        guard;
    logic        sticky;
    logic        huge;
    logic        nan;
    logic [1:0]  rm;
    logic        w32;
  } cvt_t;

  typedef struct packed {
    logic [63:0] val;
    logic [1:0]  flags;
  } out_t;

  function automatic cvt_t unpack_op(input logic [67:0] a, input logic dbl,
                                     input logic w32, input logic [1:0] rm,
                                     input logic v);
    cvt_t               o;
    logic [10:0]        ex;
    logic               all_ones;
    logic               frac_nz;
    logic [63:0]        m64;
    logic signed [12:0] e;
    logic [127:0]       fx;
    o       = '0;
    o.valid = v;
    o.rm    = rm;
    o.w32   = w32;
    // Mantissa is left-aligned so bit 63 carries the hidden bit for both formats
    if (dbl) begin
      o.sign   = a[63];
      ex       = a[62:52];
      all_ones = &a[62:52];
      frac_nz  = |a[51:0];
      m64      = {|a[62:52], a[51:0], 11'b0};
      e        = $signed({2'b00, ex}) - 13'sd1023;
    end else begin
      o.sign   = a[31];
      ex       = {3'b000, a[30:23]};
      all_ones = &a[30:23];
      frac_nz  = |a[22:0];
      m64      = {|a[30:23], a[22:0], 40'b0};
      e        = $signed({2'b00, ex}) - 13'sd127;
    end
    o.nan  = all_ones & frac_nz;
    o.huge = all_ones ? ~frac_nz : (e > 13'sd63);
    fx     = '0;
    if (e >= 13'sd0 && e <= 13'sd63) begin
      fx       = {m64, 64'b0} >> (6'd63 - e[5:0]);
      o.mag    = fx[127:64];
      o.guard  = fx[63];
      o.sticky = |fx[62:0];
    end else if (e == -13'sd1) begin
      o.guard  = m64[63];
      o.sticky = |m64[62:0];
    end else if (e < -13'sd1) begin
      o.sticky = |m64;
    end
    return o;
  endfunction

  function automatic out_t round_op(input cvt_t c);
    out_t        o;
    logic        any;
    logic        inc;
    logic [64:0] r;
    logic [64:0] lim;
    logic        ovf;
    logic [63:0] min_int;
    logic [63:0] max_int;
    any = c.guard | c.sticky;
    case (c.rm)
      2'd0:    inc = c.guard & (c.sticky | c.mag[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = c.sign & any;
      default: inc = ~c.sign & any;
    endcase
    r = {1'b0, c.mag} + {64'b0, inc};
    // Negative range reaches one further than positive, so -2^63/-2^31 stay valid
    if (c.w32) lim = c.sign ? 65'h0_0000_0000_8000_0000 : 65'h0_0000_0000_7FFF_FFFF;
    else       lim = c.sign ? 65'h0_8000_0000_0000_0000 : 65'h0_7FFF_FFFF_FFFF_FFFF;
    ovf     = c.huge | (r > lim);
    min_int = c.w32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    max_int = c.w32 ? 64'h0000_0000_7FFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
    if (c.nan)    o.val = min_int;
    else if (ovf) o.val = c.sign ? min_int : max_int;
    else          o.val = c.sign ? -r[63:0] : r[63:0];
    o.flags = {c.nan | ovf, any & ~(c.nan | ovf)};
    return o;
  endfunction

  cvt_t s1  [LANES];
  cvt_t fin [LANES];
  out_t rnd [LANES];
  logic unused_bits;

  always_comb begin
    unused_bits = ^fpcsr;
    for (int l = 0; l < LANES; l++) begin
      s1[l]       = unpack_op(A[l*68 +: 68], isDBL[l], is32b[l], fpcsr[RM_LSB +: 2], en[l]);
      unused_bits = unused_bits ^ (^A[l*68+64 +: 4]);
    end
  end

  generate
    if (STAGES == 1) begin : g_direct
      always_comb begin
        for (int l = 0; l < LANES; l++) fin[l] = s1[l];
      end
    end else begin : g_pipe
      // Stage 1 holds the unpacked/shifted operand; any further entries are plain delay
      cvt_t pipe [LANES][STAGES-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int l = 0; l < LANES; l++)
            for (int k = 0; k < STAGES-1; k++) pipe[l][k] <= '0;
        end else if (clkEn) begin
          for (int l = 0; l < LANES; l++) begin
            pipe[l][0] <= s1[l];
            for (int k = 1; k < STAGES-1; k++) pipe[l][k] <= pipe[l][k-1];
          end
        end
      end

      always_comb begin
        for (int l = 0; l < LANES; l++) fin[l] = pipe[l][STAGES-2];
      end
    end
  endgenerate

  always_comb begin
    for (int l = 0; l < LANES; l++) rnd[l] = round_op(fin[l]);
  end

  // Idle lanes present zero result and flags so downstream ORs see nothing stale
  always_ff @(posedge clk) begin
    if (rst) begin
      res    <= '0;
      res_en <= '0;
      exc    <= '0;
    end else if (clkEn) begin
      for (int l = 0; l < LANES; l++) begin
        res_en[l]       <= fin[l].valid;
        res[l*64 +: 64] <= fin[l].valid ? rnd[l].val : 64'd0;
        exc[l*2 +: 2]   <= fin[l].valid ? rnd[l].flags : 2'b00;
      end
    end
  end

`ifdef FPCVT_STICKY_EN
  logic [1:0] exc_or;

  always_comb begin
    exc_or = '0;
    for (int l = 0; l < LANES; l++) exc_or = exc_or | exc[l*2 +: 2];
  end

  // Clear is applied before the OR, so flags arriving with a clear survive it
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_exc <= '0;
    end else if (clkEn && |res_en) begin
      sticky_exc <= (sticky_clr ? 2'b00 : sticky_exc) | exc_or;
    end else if (sticky_clr) begin
      sticky_exc <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fun_fpcvt_lanes.sv
// Directed bench for fun_fpcvt_lanes: per-lane scoreboard of expected result, flags and arrival advance count.
module tb_fun_fpcvt_lanes;
  localparam int LANES  = 3;
  localparam int STAGES = 2;
  localparam int RM_LSB = 0;
  localparam logic [1:0] RNE = 2'd0, RZ = 2'd1, RDN = 2'd2, RUP = 2'd3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           fpcsr;
  logic                  clkEn;
  logic [LANES-1:0]      en;
  logic [LANES*68-1:0]   A;
  logic [LANES-1:0]      isDBL;
  logic [LANES-1:0]      is32b;
  logic [LANES*64-1:0]   res;
  logic [LANES-1:0]      res_en;
  logic [LANES*2-1:0]    exc;
`ifdef FPCVT_STICKY_EN
  logic                  sticky_clr;
  logic [1:0]            sticky_exc;
`endif

  fun_fpcvt_lanes #(.LANES(LANES), .STAGES(STAGES), .RM_LSB(RM_LSB)) dut (
    .clk(clk),
    .rst(rst),
    .fpcsr(fpcsr),
    .clkEn(clkEn),
    .en(en),
    .A(A),
    .isDBL(isDBL),
    .is32b(is32b),
`ifdef FPCVT_STICKY_EN
    .sticky_clr(sticky_clr),
    .sticky_exc(sticky_exc),
`endif
    .res(res),
    .res_en(res_en),
    .exc(exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [1:0]  exc;
    logic [31:0] due;
  } exp_t;

  exp_t        sb [LANES][$];
  exp_t        head;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] adv_cnt = 0;
  logic        last_adv = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic setRm(input logic [1:0] rm);
    fpcsr = $urandom();
    fpcsr[RM_LSB +: 2] = rm;
  endtask

  task automatic applyStimulus(input int lane, input logic [63:0] op, input logic dbl,
                               input logic w32, input logic [63:0] eres, input logic [1:0] eexc);
    en[lane]            = 1'b1;
    A[lane*68 +: 68]    = {4'h5, op};
    isDBL[lane]         = dbl;
    is32b[lane]         = w32;
    sb[lane].push_back('{res: eres, exc: eexc, due: adv_cnt + 32'(STAGES)});
  endtask

  task automatic tick();
    @(negedge clk);
    en = '0;
  endtask

  // An edge advances the pipe only when clkEn is high and reset is low
  always @(posedge clk) begin
    last_adv = clkEn & ~rst;
    if (last_adv) adv_cnt = adv_cnt + 1;
  end

  always @(negedge clk) begin
    if (last_adv) begin
      for (int i = 0; i < LANES; i++) begin
        if (res_en[i]) begin
          checks++;
          assert (sb[i].size() != 0) else begin
            errors++;
            $error("[TB] FAIL unexpected lane%0d: observed res_en=1 res=%h expected no result", i, res[i*64 +: 64]);
          end
          if (sb[i].size() != 0) begin
            head = sb[i].pop_front();
            checkOutput($sformatf("res lane%0d", i), res[i*64 +: 64], head.res);
            checkOutput($sformatf("exc lane%0d", i), {62'b0, exc[i*2 +: 2]}, {62'b0, head.exc});
            checkOutput($sformatf("latency lane%0d", i), {32'b0, adv_cnt}, {32'b0, head.due});
          end
        end else if (sb[i].size() != 0) begin
          checks++;
          assert (sb[i][0].due > adv_cnt) else begin
            errors++;
            $error("[TB] FAIL missing lane%0d: observed no result at advance %0d, expected at %0d", i, adv_cnt, sb[i][0].due);
            void'(sb[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pending;
    rst   = 1'b1;
    clkEn = 1'b0;
    en    = '0;
    A     = '0;
    isDBL = '0;
    is32b = '0;
    fpcsr = '0;
`ifdef FPCVT_STICKY_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset res_en", {61'b0, res_en}, 64'd0);
    checkOutput("reset res", res[63:0], 64'd0);
    checkOutput("reset exc", {58'b0, exc}, 64'd0);
`ifdef FPCVT_STICKY_EN
    checkOutput("reset sticky", {62'b0, sticky_exc}, 64'd0);
`endif
    rst   = 1'b0;
    clkEn = 1'b1;

    // Rounding modes on lane 0, back to back, with rm changing every cycle
    setRm(RNE); applyStimulus(0, 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01); tick();
    setRm(RNE); applyStimulus(0, 64'h4004_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01); tick();
    setRm(RDN); applyStimulus(0, 64'hC004_0000_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 2'b01); tick();
    setRm(RZ);  applyStimulus(0, 64'hC004_0000_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01); tick();

    // Saturation, NaN, signed zero
    setRm(RNE);
    applyStimulus(0, 64'h4415_AF1D_78B5_8C40, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10);
    applyStimulus(1, 64'h7FF8_0000_0000_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 2'b10);
    applyStimulus(2, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd0, 2'b00);
    tick();
    applyStimulus(0, 64'hC3E0_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 2'b00);
    applyStimulus(1, 64'h43E0_0000_0000_0000, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10);
    applyStimulus(2, 64'hFFF0_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 2'b10);
    tick();
    applyStimulus(0, 64'hDEAD_BEEF_CF00_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 2'b00);
    applyStimulus(1, 64'h1234_5678_4F00_0000, 1'b0, 1'b1, 64'h0000_0000_7FFF_FFFF, 2'b10);
    applyStimulus(2, 64'h3FE0_0000_0000_0000, 1'b1, 1'b0, 64'd0, 2'b01);
    tick();
    // Rounding up past 2^31-1 must saturate in 32-bit mode only
    applyStimulus(0, 64'h41DF_FFFF_FFC0_0000, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 2'b00);
    applyStimulus(1, 64'h41DF_FFFF_FFE0_0000, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 2'b10);
    applyStimulus(2, 64'h41DF_FFFF_FFE0_0000, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 2'b01);
    tick();

    // Denormals and sign-directed rounding of small values
    setRm(RUP);
    applyStimulus(0, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 64'd1, 2'b01);
    applyStimulus(1, 64'hBFF8_0000_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    applyStimulus(2, 64'hFFFF_FFFF_7FC0_0000, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 2'b10);
    tick();
    setRm(RDN);
    applyStimulus(0, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01);
    applyStimulus(1, 64'hAAAA_AAAA_3F80_0000, 1'b0, 1'b0, 64'd1, 2'b00);
    applyStimulus(2, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 64'd0, 2'b00);
    tick();

    // Same single-precision op on every lane in one cycle
    setRm(RZ);
    for (int l = 0; l < LANES; l++)
      applyStimulus(l, 64'hDEAD_BEEF_406C_CCCD, 1'b0, 1'b1, 64'd3, 2'b01);
    tick();
    repeat (3) tick();

    // Stall while an op is in flight; ops offered during the stall are ignored
    setRm(RZ);
    applyStimulus(1, 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd1, 2'b01);
    @(negedge clk);
    clkEn = 1'b0;
    en    = 3'b101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall wait %0d", c), {63'b0, res_en[1]}, 64'd0);
    end
    en    = '0;
    clkEn = 1'b1;
    @(negedge clk);
    checkOutput("stall arrival", {63'b0, res_en[1]}, 64'd1);
    clkEn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold res_en %0d", c), {63'b0, res_en[1]}, 64'd1);
      checkOutput($sformatf("hold res %0d", c), res[64 +: 64], 64'd1);
      checkOutput($sformatf("hold exc %0d", c), {62'b0, exc[2 +: 2]}, 64'd1);
    end
    clkEn = 1'b1;
    repeat (2) tick();

    // Reset with two ops in flight: nothing may emerge afterwards
    setRm(RNE);
    applyStimulus(0, 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01);
    applyStimulus(2, 64'h4004_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01);
    @(negedge clk);
    en  = '0;
    rst = 1'b1;
    for (int l = 0; l < LANES; l++) sb[l].delete();
    @(negedge clk);
    checkOutput("flush res_en", {61'b0, res_en}, 64'd0);
    checkOutput("flush res", res[63:0], 64'd0);
    rst = 1'b0;
`ifdef FPCVT_STICKY_EN
    checkOutput("flush sticky", {62'b0, sticky_exc}, 64'd0);
    setRm(RNE);
    applyStimulus(0, 64'h4415_AF1D_78B5_8C40, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10); tick();
    applyStimulus(0, 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01); tick();
    applyStimulus(0, 64'h4000_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b00); tick();
    checkOutput("sticky overflow", {62'b0, sticky_exc}, 64'd2);
    applyStimulus(0, 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 2'b01); tick();
    checkOutput("sticky accumulate", {62'b0, sticky_exc}, 64'd3);
    sticky_clr = 1'b1;
    tick();
    checkOutput("sticky clear clean", {62'b0, sticky_exc}, 64'd0);
    tick();
    checkOutput("sticky clear with flag", {62'b0, sticky_exc}, 64'd1);
    sticky_clr = 1'b0;
`endif
    repeat (6) tick();

    pending = 0;
    for (int c = 0; c < 20; c++) begin
      pending = 0;
      for (int l = 0; l < LANES; l++) pending += sb[l].size();
      if (pending != 0) tick();
    end
    checkOutput("drain", 64'(pending), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
